// File: rtl/cde_pkg.sv
// Shared constants for the credential sequencer: opcodes, completion codes,
// datapath control bit positions and the sequencer state encoding.
package cde_pkg;

  localparam int CTRL_W = 15;

  localparam logic [1:0] OP_BOOT  = 2'd0;
  localparam logic [1:0] OP_FETCH = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;
  localparam logic [1:0] OP_ILL   = 2'd3;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_MISS = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_ILL  = 2'd3;

  // Bit positions inside ctrl, LSB first
  localparam int C_CAM_START      = 0;
  localparam int C_START_DEC      = 1;
  localparam int C_START_ENC      = 2;
  localparam int C_FLASH_PASS_REG = 3;
  localparam int C_FLASH_ACC_REG  = 4;
  localparam int C_FOA_REG        = 5;
  localparam int C_FOA_SEL        = 6;
  localparam int C_PASS_ENC_REG   = 7;
  localparam int C_NOP_SEL        = 8;
  localparam int C_PLAIN_REG      = 9;
  localparam int C_LM_REG         = 10;
  localparam int C_LM_SEL         = 11;
  localparam int C_OUT_REG        = 12;
  localparam int C_WRITE_EN       = 13;
  localparam int C_BOOT_LOOD      = 14;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_B_RD, ST_B_WR,
    ST_F_LAT, ST_F_CAM, ST_F_RD, ST_F_DEC, ST_F_MK, ST_F_ENC, ST_F_OUT,
    ST_S_LAT, ST_S_KEY, ST_S_ENC, ST_S_WR, ST_S_FL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/cde_wdog.sv
// Clearable, saturating cycle counter used both as the per-state watchdog
// and as the in-state cycle index for fixed-latency steps.
module cde_wdog #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  assign expired = (count == CNT_W'(TIMEOUT));

  // Count cycles spent in the current state; stop at TIMEOUT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                count <= '0;
    else if (clr)            count <= '0;
    else if (en && !expired) count <= count + 1'b1;
  end

endmodule

// File: rtl/cde_seq.sv
// Credential sequencer: drives the CAM / decryptor / encryptor / flash
// datapath through BOOT (load all slots), FETCH and STORE operations.
module cde_seq
  import cde_pkg::*;
#(
  parameter int CAM_LAT = 2,
  parameter int TIMEOUT = 1023,
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_slot,
  input  logic        match,
  input  logic        dec_done,
  input  logic        ready_encryption,
  output logic        flash_rd_req,
  input  logic        flash_rd_ack,
  output logic        flash_wr_req,
  input  logic        flash_wr_ack,
  output logic [14:0] ctrl,
  output logic [3:0]  write_add,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err_code
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] wd_count;
  logic             wd_expired;
  logic             first;
  logic             accept;
  logic [3:0]       idx, slot_q;
  logic [1:0]       err_q, err_nxt;

  // cmd_ready is held low while reset is asserted so nothing is accepted then
  assign cmd_ready = rst && (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign err_code  = err_q;
  assign accept    = cmd_valid && cmd_ready;
  assign first     = (wd_count == '0);

  cde_wdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_next != state),
    .en      (state != ST_IDLE),
    .count   (wd_count),
    .expired (wd_expired)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Command slot latch, BOOT slot index and the sticky completion code
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q <= '0;
      idx    <= '0;
      err_q  <= ERR_OK;
    end else begin
      if (accept) begin
        slot_q <= cmd_slot;
        idx    <= '0;
      end else if (state == ST_B_WR && state_next == ST_B_RD) begin
        idx <= idx + 4'd1;
      end
      if (state_next == ST_DONE && state != ST_DONE) err_q <= err_nxt;
      else if (accept)                               err_q <= ERR_OK;
    end
  end

  // Next state and datapath controls; in wait states the awaited event is
  // checked before the watchdog so a same-cycle arrival counts as success
  always_comb begin
    state_next   = state;
    err_nxt      = ERR_OK;
    ctrl         = '0;
    flash_rd_req = 1'b0;
    flash_wr_req = 1'b0;
    write_add    = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_BOOT:  state_next = ST_B_RD;
            OP_FETCH: state_next = ST_F_LAT;
            OP_STORE: state_next = ST_S_LAT;
            default: begin
              state_next = ST_DONE;
              err_nxt    = ERR_ILL;
            end
          endcase
        end
      end
      ST_B_RD: begin
        write_add    = idx;
        flash_rd_req = 1'b1;
        if (flash_rd_ack) begin
          ctrl[C_FOA_REG] = 1'b1;
          state_next      = ST_B_WR;
        end else if (wd_expired) begin
          state_next = ST_DONE;
          err_nxt    = ERR_TMO;
        end
      end
      ST_B_WR: begin
        write_add        = idx;
        ctrl[C_WRITE_EN] = 1'b1;
        state_next       = (idx == 4'(ENTRIES - 1)) ? ST_DONE : ST_B_RD;
      end
      ST_F_LAT: begin
        ctrl[C_FOA_REG] = 1'b1;
        ctrl[C_FOA_SEL] = 1'b1;
        state_next      = ST_F_CAM;
      end
      ST_F_CAM: begin
        ctrl[C_CAM_START] = first;
        if (wd_count == CNT_W'(CAM_LAT)) begin
          if (match) begin
            state_next = ST_F_RD;
          end else begin
            state_next = ST_DONE;
            err_nxt    = ERR_MISS;
          end
        end
      end
      ST_F_RD: begin
        ctrl[C_BOOT_LOOD] = 1'b1;
        flash_rd_req      = 1'b1;
        if (flash_rd_ack) begin
          ctrl[C_PASS_ENC_REG] = 1'b1;
          state_next           = ST_F_DEC;
        end else if (wd_expired) begin
          state_next = ST_DONE;
          err_nxt    = ERR_TMO;
        end
      end
      ST_F_DEC: begin
        ctrl[C_BOOT_LOOD] = 1'b1;
        ctrl[C_START_DEC] = first;
        if (dec_done) begin
          state_next = ST_F_MK;
        end else if (wd_expired) begin
          state_next = ST_DONE;
          err_nxt    = ERR_TMO;
        end
      end
      ST_F_MK: begin
        ctrl[C_BOOT_LOOD] = 1'b1;
        ctrl[C_NOP_SEL]   = 1'b1;
        ctrl[C_LM_SEL]    = 1'b1;
        ctrl[C_PLAIN_REG] = 1'b1;
        ctrl[C_LM_REG]    = 1'b1;
        state_next        = ST_F_ENC;
      end
      ST_F_ENC: begin
        ctrl[C_BOOT_LOOD] = 1'b1;
        ctrl[C_NOP_SEL]   = 1'b1;
        ctrl[C_LM_SEL]    = 1'b1;
        ctrl[C_START_ENC] = first;
        if (ready_encryption) begin
          state_next = ST_F_OUT;
        end else if (wd_expired) begin
          state_next = ST_DONE;
          err_nxt    = ERR_TMO;
        end
      end
      ST_F_OUT: begin
        ctrl[C_BOOT_LOOD] = 1'b1;
        ctrl[C_NOP_SEL]   = 1'b1;
        ctrl[C_LM_SEL]    = 1'b1;
        ctrl[C_OUT_REG]   = 1'b1;
        state_next        = ST_DONE;
      end
      ST_S_LAT: begin
        ctrl[C_FOA_REG] = 1'b1;
        ctrl[C_FOA_SEL] = 1'b1;
        state_next      = ST_S_KEY;
      end
      ST_S_KEY: begin
        // First cycle captures the account register, second the key inputs
        if (first) begin
          ctrl[C_FLASH_ACC_REG] = 1'b1;
        end else begin
          ctrl[C_PLAIN_REG] = 1'b1;
          ctrl[C_LM_REG]    = 1'b1;
          state_next        = ST_S_ENC;
        end
      end
      ST_S_ENC: begin
        ctrl[C_START_ENC] = first;
        if (ready_encryption) begin
          ctrl[C_FLASH_PASS_REG] = 1'b1;
          state_next             = ST_S_WR;
        end else if (wd_expired) begin
          state_next = ST_DONE;
          err_nxt    = ERR_TMO;
        end
      end
      ST_S_WR: begin
        write_add        = slot_q;
        ctrl[C_WRITE_EN] = 1'b1;
        state_next       = ST_S_FL;
      end
      ST_S_FL: begin
        write_add    = slot_q;
        flash_wr_req = 1'b1;
        if (flash_wr_ack) begin
          state_next = ST_DONE;
        end else if (wd_expired) begin
          state_next = ST_DONE;
          err_nxt    = ERR_TMO;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cde_seq.sv
// Directed bench for cde_seq with a scoreboard of expected per-command results.
module tb_cde_seq;
  import cde_pkg::*;

  localparam int CAM_LAT = 2;
  localparam int TIMEOUT = 31;
  localparam int ENTRIES = 16;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_slot;
  logic        match, dec_done, ready_encryption;
  logic        flash_rd_req, flash_rd_ack, flash_wr_req, flash_wr_ack;
  logic [14:0] ctrl;
  logic [3:0]  write_add;
  logic        busy, done;
  logic [1:0]  err_code;

  typedef struct {
    logic [1:0] err;
    int         wren;
    int         outs;
    int         rdreq;
    int         wrreq;
    int         cams;
    int         cam2done;
    int         done_cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [14:0] strobes;

  cde_seq #(.CAM_LAT(CAM_LAT), .TIMEOUT(TIMEOUT), .ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_slot(cmd_slot), .match(match), .dec_done(dec_done),
    .ready_encryption(ready_encryption), .flash_rd_req(flash_rd_req),
    .flash_rd_ack(flash_rd_ack), .flash_wr_req(flash_wr_req),
    .flash_wr_ack(flash_wr_ack), .ctrl(ctrl), .write_add(write_add),
    .busy(busy), .done(done), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] err, input int wren, input int outs,
                          input int rdreq, input int wrreq, input int cams,
                          input int cam2done, input int done_cyc);
    exp_t e;
    e.err = err; e.wren = wren; e.outs = outs; e.rdreq = rdreq;
    e.wrreq = wrreq; e.cams = cams; e.cam2done = cam2done; e.done_cyc = done_cyc;
    sb.push_back(e);
  endtask

  task automatic zero_inputs();
    cmd_valid = 0; cmd_op = 0; cmd_slot = 0; match = 0; dec_done = 0;
    ready_encryption = 0; flash_rd_ack = 0; flash_wr_ack = 0;
  endtask

  // Issue one command, play the CAM/crypto/flash responders, collect events.
  // Delays of 0 mean the responder never answers.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] slot, input logic hit,
                         input int rd_dly, input int dec_dly, input int rdy_dly,
                         input int wr_dly, input bit spam, input bit abort_enc);
    int n_wren = 0, n_out = 0, n_rdreq = 0, n_wrreq = 0, n_cam = 0, viol = 0;
    int cam_cyc = 0, cam2done = -1, done_cyc = -1, bidx = 0;
    int dec_t = 0, rdy_t = 0, mt_t = 0, rd_cyc = 0, wr_cyc = 0;
    bit got_done = 0, enc_seen = 0, done_clean = 0;
    logic [1:0]  done_err = 0;
    logic [14:0] prev_ctrl = 0;
    logic nxt_rd, nxt_wr, nxt_dec, nxt_rdy, nxt_match;
    exp_t e;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_op = op; cmd_slot = slot;
    @(posedge clk); #1;
    if (spam) cmd_op = OP_FETCH; else cmd_valid = 0;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      @(negedge clk);
      if ((ctrl & prev_ctrl & strobes) != 0) viol++;
      prev_ctrl = ctrl;
      if (ctrl[C_WRITE_EN]) begin
        check("write_add", {28'd0, write_add}, (op == OP_BOOT) ? bidx : {28'd0, slot});
        bidx++;
        n_wren++;
      end
      if (ctrl[C_OUT_REG]) n_out++;
      if (flash_rd_req) begin n_rdreq++; rd_cyc++; end else rd_cyc = 0;
      if (flash_wr_req) begin n_wrreq++; wr_cyc++; end else wr_cyc = 0;
      if (ctrl[C_CAM_START]) begin n_cam++; cam_cyc = cyc; mt_t = CAM_LAT; end
      if (ctrl[C_START_DEC]) dec_t = dec_dly;
      if (ctrl[C_START_ENC]) begin rdy_t = rdy_dly; enc_seen = 1; end
      if (done) begin
        got_done   = 1;
        done_err   = err_code;
        done_cyc   = cyc;
        done_clean = (ctrl == 0) && !flash_rd_req && !flash_wr_req;
        if (n_cam > 0) cam2done = cyc - cam_cyc;
      end
      if (abort_enc && enc_seen) break;
      nxt_rd  = flash_rd_req && (rd_cyc == rd_dly);
      nxt_wr  = flash_wr_req && (wr_cyc == wr_dly);
      nxt_dec = 0; if (dec_t > 0) begin dec_t--; nxt_dec = (dec_t == 0); end
      nxt_rdy = 0; if (rdy_t > 0) begin rdy_t--; nxt_rdy = (rdy_t == 0); end
      nxt_match = 0; if (mt_t > 0) begin mt_t--; nxt_match = (mt_t == 0) && hit; end
      @(posedge clk); #1;
      flash_rd_ack = nxt_rd; flash_wr_ack = nxt_wr; dec_done = nxt_dec;
      ready_encryption = nxt_rdy; match = nxt_match;
      if (got_done) begin cmd_valid = 0; break; end
    end
    if (abort_enc) begin
      check("reached_f_enc", enc_seen, 1);
      return;
    end
    e = sb.pop_front();
    check("done_seen", got_done, 1);
    check("err_code", done_err, e.err);
    check("write_en_count", n_wren, e.wren);
    check("out_reg_count", n_out, e.outs);
    check("cam_start_count", n_cam, e.cams);
    check("strobe_repeat", viol, 0);
    check("quiet_at_done", done_clean, 1);
    if (e.rdreq >= 0)    check("rd_req_cycles", n_rdreq, e.rdreq);
    if (e.wrreq >= 0)    check("wr_req_cycles", n_wrreq, e.wrreq);
    if (e.cam2done >= 0) check("cam_to_done", cam2done, e.cam2done);
    if (e.done_cyc >= 0) check("accept_to_done", done_cyc, e.done_cyc);
  endtask

  initial begin
    int n_done;
    strobes = '1;
    strobes[C_FOA_SEL] = 0; strobes[C_NOP_SEL] = 0;
    strobes[C_LM_SEL] = 0;  strobes[C_BOOT_LOOD] = 0;
    rst = 0;
    zero_inputs();
    #12;
    check("rst_ctrl", ctrl, 0);
    check("rst_write_add", write_add, 0);
    check("rst_reqs", {flash_rd_req, flash_wr_req}, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_code, 0);
    check("rst_ready_low", cmd_ready, 0);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    check("ready_after_rst", cmd_ready, 1);

    // BOOT, ack one cycle after each request
    push_exp(ERR_OK, 16, 0, 32, 0, 0, -1, -1);
    run_cmd(OP_BOOT, 4'd0, 0, 1, 0, 0, 0, 0, 0);

    // FETCH hit, dec_done +5, ready +10
    push_exp(ERR_OK, 0, 1, 2, 0, 1, -1, -1);
    run_cmd(OP_FETCH, 4'd0, 1, 1, 5, 10, 0, 0, 0);

    // FETCH miss
    push_exp(ERR_MISS, 0, 0, 0, 0, 1, 3, 5);
    run_cmd(OP_FETCH, 4'd0, 0, 1, 5, 10, 0, 0, 0);

    // STORE slot 7 with cmd_valid kept high (FETCH) while busy
    push_exp(ERR_OK, 1, 0, 0, 4, 0, -1, -1);
    run_cmd(OP_STORE, 4'd7, 0, 1, 0, 3, 3, 1, 0);

    // FETCH with decryptor never finishing
    push_exp(ERR_TMO, 0, 0, 2, 0, 1, -1, -1);
    run_cmd(OP_FETCH, 4'd0, 1, 1, 0, 10, 0, 0, 0);

    // Illegal opcode
    push_exp(ERR_ILL, 0, 0, 0, 0, 0, -1, 1);
    run_cmd(OP_ILL, 4'd0, 0, 1, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("err_held", err_code, ERR_ILL);
    check("idle_after_done", busy, 0);

    // Flash ack in the very cycle the watchdog expires still succeeds
    push_exp(ERR_OK, 0, 1, 32, 0, 1, -1, -1);
    run_cmd(OP_FETCH, 4'd0, 1, 31, 5, 10, 0, 0, 0);

    // Reset while waiting for the encryptor
    run_cmd(OP_FETCH, 4'd0, 1, 1, 5, 0, 0, 0, 1);
    #2; rst = 0; zero_inputs();
    #1;
    check("abort_ctrl", ctrl, 0);
    check("abort_reqs", {flash_rd_req, flash_wr_req}, 0);
    check("abort_done", done, 0);
    check("abort_busy", busy, 0);
    check("abort_write_add", write_add, 0);
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) n_done++;
    end
    @(negedge clk); rst = 1;
    if (done) n_done++;
    @(posedge clk); #1;
    if (done) n_done++;
    check("abort_no_done", n_done, 0);
    check("abort_ready", cmd_ready, 1);

    // BOOT after the aborted operation
    push_exp(ERR_OK, 16, 0, 32, 0, 0, -1, -1);
    run_cmd(OP_BOOT, 4'd0, 0, 1, 0, 0, 0, 0, 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
